// File: rtl/timer_cmp_scheduler.sv
// timer_cmp_scheduler
// Holds NR_CORES 64-bit mtimecmp registers and time-multiplexes a single
// 64-bit unsigned >= comparator across them. Each mtime tick or accepted
// mtimecmp write starts a sweep of the cores, one core per cycle. The
// per-core interrupt lines are registered from the sweep results.
// If an event arrives mid-sweep, it is remembered, and a new sweep starts
// once the current one completes.
//
// Optional feature: define TIMER_CMP_READBACK_EN to enable the mtimecmp
// readback mux on rd_data_o. Without it, rd_data_o is tied to zero.
module timer_cmp_scheduler #(
  parameter int NR_CORES = 2,
  parameter int IDX_W    = $clog2(NR_CORES)
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [63:0]         time_i,
  input  logic                tick_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [IDX_W-1:0]    wr_core_i,
  input  logic                wr_hi_i,
  input  logic [31:0]         wr_data_i,
  input  logic [IDX_W-1:0]    rd_core_i,
  input  logic                rd_hi_i,
  output logic [31:0]         rd_data_o,
  output logic [NR_CORES-1:0] timer_irq_o,
  output logic                busy_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_CORES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  r_pending;
  logic                  w_pending_nxt;
  logic [63:0]           r_snap;
  logic [63:0]           w_snap_nxt;
  logic [63:0]           r_cmp [NR_CORES];
  logic [NR_CORES-1:0]   r_irq;

  logic                  w_wr_acc;
  logic                  w_wr_in_range;
  logic                  w_evt;
  logic [63:0]           w_cmp_sel;
  logic                  w_ge;

  // A write is stalled only when it targets the core being compared right now.
  // This keeps the comparator's operand stable for that cycle.
  assign wr_ready_o    = !((r_state == ST_SCAN) && (wr_core_i == r_idx));
  assign w_wr_acc      = wr_valid_i && wr_ready_o;
  assign w_wr_in_range = (32'(wr_core_i) < 32'(NR_CORES));
  // Out-of-range writes are accepted but do not trigger a rescan.
  assign w_evt         = tick_i || (w_wr_acc && w_wr_in_range);

  assign busy_o        = (r_state == ST_SCAN);
  assign timer_irq_o   = r_irq;

  // Select the mtimecmp of the core under scan for the shared comparator
  always_comb begin
    w_cmp_sel = '1;
    for (int c = 0; c < NR_CORES; c++) begin
      if (r_idx == IDX_W'(c)) begin
        w_cmp_sel = r_cmp[c];
      end
    end
  end

  assign w_ge = (r_snap >= w_cmp_sel);

  // Scan control registers: state, index, pending flag and time snapshot
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_snap    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pending <= w_pending_nxt;
      r_snap    <= w_snap_nxt;
    end
  end

  // Next-state logic: start, advance, reload or finish a sweep
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_pending;
    w_snap_nxt    = r_snap;
    case (r_state)
      ST_IDLE: begin
        // Coincident tick and write start a single sweep.
        if (w_evt || r_pending) begin
          w_snap_nxt    = time_i;
          w_idx_nxt     = '0;
          w_pending_nxt = 1'b0;
          w_state_nxt   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_idx == LAST_IDX) begin
          if (r_pending) begin
            // Back-to-back sweep. An event arriving this very cycle is
            // remembered for the sweep after that one.
            w_snap_nxt    = time_i;
            w_idx_nxt     = '0;
            w_pending_nxt = w_evt;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_idx_nxt     = '0;
            w_pending_nxt = w_evt;
          end
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
          if (w_evt) begin
            w_pending_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_idx_nxt     = '0;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // mtimecmp storage: the addressed 32-bit half is updated on an accepted write
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int c = 0; c < NR_CORES; c++) begin
        r_cmp[c] <= '1;
      end
    end else if (w_wr_acc) begin
      for (int c = 0; c < NR_CORES; c++) begin
        if (wr_core_i == IDX_W'(c)) begin
          if (wr_hi_i) begin
            r_cmp[c][63:32] <= wr_data_i;
          end else begin
            r_cmp[c][31:0]  <= wr_data_i;
          end
        end
      end
    end
  end

  // Interrupt lines: set from the sweep result, cleared by a write to that core
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_irq <= '0;
    end else begin
      if (r_state == ST_SCAN) begin
        for (int c = 0; c < NR_CORES; c++) begin
          if (r_idx == IDX_W'(c)) begin
            r_irq[c] <= w_ge;
          end
        end
      end
      // A write never targets the core under scan (it is stalled), so this
      // clear and the scan update above never hit the same bit.
      if (w_wr_acc) begin
        for (int c = 0; c < NR_CORES; c++) begin
          if (wr_core_i == IDX_W'(c)) begin
            r_irq[c] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef TIMER_CMP_READBACK_EN
  // Readback mux: selected half of the selected core, zero when out of range
  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < NR_CORES; c++) begin
      if (rd_core_i == IDX_W'(c)) begin
        rd_data_o = rd_hi_i ? r_cmp[c][63:32] : r_cmp[c][31:0];
      end
    end
  end
`else
  logic w_rd_unused;
  assign w_rd_unused = ^{rd_core_i, rd_hi_i};
  assign rd_data_o   = '0;
`endif

endmodule

// File: tb/tb_timer_cmp_scheduler.sv
// Directed bench for timer_cmp_scheduler (NR_CORES=2). Inputs are driven
// on the falling edge, and outputs are sampled 1 ns later, well away from
// the rising edge.
module tb_timer_cmp_scheduler;

  localparam int NR    = 2;
  localparam int IW    = 1;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [63:0]   time_i;
  logic          tick_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [IW-1:0] wr_core_i;
  logic          wr_hi_i;
  logic [31:0]   wr_data_i;
  logic [IW-1:0] rd_core_i;
  logic          rd_hi_i;
  logic [31:0]   rd_data_o;
  logic [NR-1:0] timer_irq_o;
  logic          busy_o;

  int n_chk = 0;
  int n_err = 0;

  timer_cmp_scheduler #(.NR_CORES(NR), .IDX_W(IW)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .time_i      (time_i),
    .tick_i      (tick_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_core_i   (wr_core_i),
    .wr_hi_i     (wr_hi_i),
    .wr_data_i   (wr_data_i),
    .rd_core_i   (rd_core_i),
    .rd_hi_i     (rd_hi_i),
    .rd_data_o   (rd_data_o),
    .timer_irq_o (timer_irq_o),
    .busy_o      (busy_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic          tick;
    logic          wv;
    logic [IW-1:0] core;
    logic          hi;
    logic [31:0]   data;
    logic [63:0]   t;
    logic [NR-1:0] irq;
    logic          busy;
    logic          ready;
  } vec_t;

  vec_t        vt[$];
  logic [63:0] shadow [NR];

  task automatic add(input logic tick, input logic wv, input logic [IW-1:0] core,
                     input logic hi, input logic [31:0] data, input logic [63:0] t,
                     input logic [NR-1:0] irq, input logic busy, input logic ready);
    vec_t v;
    v.tick = tick; v.wv = wv; v.core = core; v.hi = hi; v.data = data;
    v.t = t; v.irq = irq; v.busy = busy; v.ready = ready;
    vt.push_back(v);
  endtask

  task automatic drive(input logic tick, input logic wv, input logic [IW-1:0] core,
                       input logic hi, input logic [31:0] data, input logic [63:0] t);
    tick_i     = tick;
    wr_valid_i = wv;
    wr_core_i  = core;
    wr_hi_i    = hi;
    wr_data_i  = data;
    time_i     = t;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge HCLK);
  endtask

  initial begin
    logic [63:0] exp_rd;
    int          k;

    HRESET = 1'b1;
    rd_core_i = '0;
    rd_hi_i   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    for (int c = 0; c < NR; c++) shadow[c] = '1;

    // Reset state
    repeat (2) @(posedge HCLK);
    cyc(); #1;
    chk("reset irq",   64'(timer_irq_o), 64'h0);
    chk("reset busy",  64'(busy_o),      64'h0);
    chk("reset ready", 64'(wr_ready_o),  64'h1);
    chk("reset rd",    64'(rd_data_o),   64'h0);
    HRESET = 1'b0;

    //   tick wv core hi data      time       irq    busy  ready
    add(1, 0, 0, 0, 32'h0,  64'h0,  2'b00, 0, 1); // 0 tick vs all-ones
    add(0, 0, 0, 0, 32'h0,  64'h0,  2'b00, 1, 0); // 1 scan idx0
    add(0, 0, 0, 0, 32'h0,  64'h0,  2'b00, 1, 1); // 2 scan idx1
    add(0, 0, 0, 0, 32'h0,  64'h0,  2'b00, 0, 1); // 3 idle, irq still 0
    add(0, 1, 0, 0, 32'h10, 64'h0,  2'b00, 0, 1); // 4 core0 lo=0x10
    add(0, 0, 1, 0, 32'h0,  64'h0,  2'b00, 1, 1); // 5
    add(0, 1, 0, 1, 32'h0,  64'h0,  2'b00, 1, 1); // 6 core0 hi=0 during idx1
    add(0, 0, 0, 0, 32'h0,  64'h5,  2'b00, 0, 1); // 7 pending rescan starts
    add(0, 0, 0, 0, 32'h0,  64'h5,  2'b00, 1, 0); // 8
    add(0, 0, 0, 0, 32'h0,  64'h5,  2'b00, 1, 1); // 9
    add(1, 0, 0, 0, 32'h0,  64'h10, 2'b00, 0, 1); // 10 tick T, time=0x10
    add(0, 0, 0, 0, 32'h0,  64'h10, 2'b00, 1, 0); // 11 T+1
    add(0, 0, 0, 0, 32'h0,  64'h10, 2'b01, 1, 1); // 12 T+2 irq0=1
    add(0, 1, 0, 1, 32'h1,  64'h10, 2'b01, 0, 1); // 13 T+3 irq1=0; core0 hi=1
    add(0, 0, 0, 0, 32'h0,  64'h10, 2'b00, 1, 0); // 14 irq0 cleared
    add(0, 0, 0, 0, 32'h0,  64'h10, 2'b00, 1, 1); // 15
    add(1, 0, 0, 0, 32'h0,  64'h11, 2'b00, 0, 1); // 16 tick time=0x11
    add(0, 0, 0, 0, 32'h0,  64'h11, 2'b00, 1, 0); // 17
    add(0, 0, 0, 0, 32'h0,  64'h11, 2'b00, 1, 1); // 18
    add(1, 0, 0, 0, 32'h0,  64'h20, 2'b00, 0, 1); // 19 tick time=0x20
    add(0, 0, 1, 0, 32'h0,  64'h20, 2'b00, 1, 1); // 20 idx0, core1 ready
    add(0, 1, 1, 1, 32'h0,  64'h20, 2'b00, 1, 0); // 21 idx1, core1 stalled
    add(0, 1, 1, 1, 32'h0,  64'h20, 2'b00, 0, 1); // 22 write lands a cycle later
    add(0, 1, 1, 0, 32'h5,  64'h20, 2'b00, 1, 1); // 23 core1 lo=5, sets pending
    add(0, 0, 0, 0, 32'h0,  64'h20, 2'b00, 1, 1); // 24 last idx, reload
    add(0, 0, 1, 0, 32'h0,  64'h20, 2'b10, 1, 1); // 25 irq1=1, still scanning
    add(0, 0, 0, 0, 32'h0,  64'h20, 2'b10, 1, 1); // 26
    add(0, 1, 0, 1, 32'h0,  64'h30, 2'b10, 0, 1); // 27 core0 hi=0 -> 0x10
    add(0, 0, 1, 0, 32'h0,  64'h30, 2'b10, 1, 1); // 28
    add(0, 1, 0, 0, 32'h40, 64'h30, 2'b11, 1, 1); // 29 clear irq0 + scan irq1
    add(0, 0, 1, 0, 32'h0,  64'h30, 2'b10, 0, 1); // 30 both took effect
    add(0, 0, 1, 0, 32'h0,  64'h30, 2'b10, 1, 1); // 31
    add(0, 0, 1, 0, 32'h0,  64'h30, 2'b10, 1, 0); // 32
    add(0, 0, 0, 0, 32'h0,  64'h30, 2'b10, 0, 1); // 33 idle

    foreach (vt[i]) begin
      cyc();
      drive(vt[i].tick, vt[i].wv, vt[i].core, vt[i].hi, vt[i].data, vt[i].t);
      rd_core_i = IW'(i % 2);
      rd_hi_i   = 1'((i / 2) % 2);
      #1;
      chk($sformatf("row%0d irq", i),   64'(timer_irq_o), 64'(vt[i].irq));
      chk($sformatf("row%0d busy", i),  64'(busy_o),      64'(vt[i].busy));
      chk($sformatf("row%0d ready", i), 64'(wr_ready_o),  64'(vt[i].ready));
`ifdef TIMER_CMP_READBACK_EN
      exp_rd = rd_hi_i ? {32'h0, shadow[i % 2][63:32]} : {32'h0, shadow[i % 2][31:0]};
`else
      exp_rd = 64'h0;
`endif
      chk($sformatf("row%0d rd", i), 64'(rd_data_o), exp_rd);
      if (vt[i].wv && vt[i].ready) begin
        if (vt[i].hi) shadow[vt[i].core][63:32] = vt[i].data;
        else          shadow[vt[i].core][31:0]  = vt[i].data;
      end
    end

    // Continuous ticks: sweeps run back to back, and each reload samples time_i
    cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h3F, 64'h30);
    #1;
    chk("cmp0 lo=3F ready", 64'(wr_ready_o), 64'h1);
    repeat (4) begin
      cyc();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 64'h30);
    end
    for (int c = 0; c < 10; c++) begin
      cyc();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 64'h3C + 64'(c));
      #1;
      if (c >= 1) chk($sformatf("burst c%0d busy", c), 64'(busy_o), 64'h1);
      if (c == 2) chk("burst c2 irq", 64'(timer_irq_o), 64'b10);
      if (c == 4) chk("burst c4 irq", 64'(timer_irq_o), 64'b10);
      if (c == 6) chk("burst c6 irq", 64'(timer_irq_o), 64'b11);
    end
    cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 64'h45);
    #1;
    chk("burst tail busy", 64'(busy_o), 64'h1);
    k = 0;
    while (busy_o && k < 20) begin
      cyc(); #1;
      k++;
    end
    chk("burst drains busy", 64'(busy_o), 64'h0);
    chk("burst final irq", 64'(timer_irq_o), 64'b11);

    // Reset in the middle of a sweep
    cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h50);
    #1;
    chk("pre-rst busy", 64'(busy_o), 64'h0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h50);
    #1;
    chk("mid-scan busy", 64'(busy_o), 64'h1);
    chk("mid-scan irq", 64'(timer_irq_o), 64'b11);
    HRESET = 1'b1;
    cyc();
    HRESET = 1'b0;
    #1;
    chk("post-rst irq",   64'(timer_irq_o), 64'h0);
    chk("post-rst busy",  64'(busy_o),      64'h0);
    chk("post-rst ready", 64'(wr_ready_o),  64'h1);

    // mtimecmp are all ones again: max-1 does not fire, max does
    cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (3) begin
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    #1;
    chk("max-1 irq", 64'(timer_irq_o), 64'h0);
    chk("max-1 busy", 64'(busy_o), 64'h0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) begin
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    #1;
    chk("max irq", 64'(timer_irq_o), 64'b11);

    // Tick and write in the same idle cycle start a single sweep
    cyc();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    chk("tick+wr ready", 64'(wr_ready_o), 64'h1);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    chk("tick+wr s1 busy", 64'(busy_o), 64'h1);
    chk("tick+wr s1 irq", 64'(timer_irq_o), 64'b01);
    cyc(); #1;
    chk("tick+wr s2 busy", 64'(busy_o), 64'h1);
    cyc(); #1;
    chk("tick+wr s3 busy", 64'(busy_o), 64'h0);
    chk("tick+wr s3 irq", 64'(timer_irq_o), 64'b11);
    cyc(); #1;
    chk("tick+wr s4 busy", 64'(busy_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
